// File: rtl/prog_loader.sv
// prog_loader: boot/reload sequencer for the 9-bit CPU.
// Takes a length-prefixed program image over a valid/ready stream, writes it
// into instruction memory and holds the CPU in reset until the image is done.
// Optional trailing-checksum stage is enabled with `define PROG_LOADER_CHECKSUM_EN.
module prog_loader #(
  parameter int g_WORD_WIDTH = 9,
  parameter int g_IMEM_ADDR  = 11,
  parameter int g_AUTOSTART  = 1
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_start,
  input  logic                    i_s_valid,
  output logic                    o_s_ready,
  input  logic [g_WORD_WIDTH-1:0] i_s_data,
  output logic                    o_imem_we,
  output logic [g_IMEM_ADDR-1:0]  o_imem_addr,
  output logic [g_WORD_WIDTH-1:0] o_imem_data,
  output logic                    o_cpu_rst,
  output logic                    o_busy,
  output logic                    o_err,
  output logic [g_IMEM_ADDR:0]    o_count
);

  localparam logic [31:0] CAPACITY = 32'd1 << g_IMEM_ADDR;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LEN0    = 3'd1,
    LEN1    = 3'd2,
    DATA    = 3'd3,
`ifdef PROG_LOADER_CHECKSUM_EN
    CHK     = 3'd4,
`endif
    RELEASE = 3'd5,
    RUN     = 3'd6
  } state_t;

`ifdef PROG_LOADER_CHECKSUM_EN
  localparam state_t POST_DATA = CHK;
`else
  localparam state_t POST_DATA = RELEASE;
`endif

  state_t      state_q;
  state_t      state_d;
  logic [11:0] len_q;
  logic [11:0] hdr_len;
  logic        xfer;
  logic        hdr_oversize;
  logic        last_word;
  logic        auto_q;
  logic        load_begin;
  logic        ready_d;
  logic        busy_d;
  logic        cpu_rst_d;
`ifdef PROG_LOADER_CHECKSUM_EN
  logic [g_WORD_WIDTH-1:0] chk_q;
  logic                    chk_match;
  assign chk_match = (i_s_data == chk_q);
`endif

  // The second header word carries the top three length bits.
  assign xfer         = i_s_valid & o_s_ready;
  assign hdr_len      = {i_s_data[2:0], len_q[8:0]};
  assign hdr_oversize = 32'(hdr_len) > CAPACITY;
  assign last_word    = (32'(o_count) + 32'd1) == 32'(len_q);
  assign load_begin   = ((state_q == IDLE) || (state_q == RUN)) && (state_d == LEN0);

  // State register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic; i_start only matters in IDLE and RUN, autostart only once after reset.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (i_start || auto_q) state_d = LEN0;
      LEN0:    if (xfer) state_d = LEN1;
      LEN1: begin
        if (xfer) begin
          if (hdr_len == 12'd0)  state_d = POST_DATA;
          else if (hdr_oversize) state_d = IDLE;
          else                   state_d = DATA;
        end
      end
      DATA:    if (xfer && last_word) state_d = POST_DATA;
`ifdef PROG_LOADER_CHECKSUM_EN
      CHK:     if (xfer) state_d = chk_match ? RELEASE : IDLE;
`endif
      RELEASE: state_d = RUN;
      RUN:     if (i_start) state_d = LEN0;
      default: state_d = IDLE;
    endcase
  end

  // Decode the upcoming state into the values of the registered status outputs.
  always_comb begin
    ready_d   = (state_d == LEN0) || (state_d == LEN1) || (state_d == DATA);
`ifdef PROG_LOADER_CHECKSUM_EN
    ready_d   = ready_d || (state_d == CHK);
`endif
    busy_d    = ready_d || (state_d == RELEASE);
    cpu_rst_d = (state_d != RUN);
  end

  // Registered outputs, header capture, write strobe generation and error tracking.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_s_ready   <= 1'b0;
      o_busy      <= 1'b0;
      o_cpu_rst   <= 1'b1;
      o_imem_we   <= 1'b0;
      o_imem_addr <= '0;
      o_imem_data <= '0;
      o_err       <= 1'b0;
      o_count     <= '0;
      len_q       <= '0;
      auto_q      <= (g_AUTOSTART != 0);
`ifdef PROG_LOADER_CHECKSUM_EN
      chk_q       <= '0;
`endif
    end else begin
      o_s_ready <= ready_d;
      o_busy    <= busy_d;
      o_cpu_rst <= cpu_rst_d;
      o_imem_we <= 1'b0;
      auto_q    <= 1'b0;
      if (load_begin) begin
        o_err   <= 1'b0;
        o_count <= '0;
`ifdef PROG_LOADER_CHECKSUM_EN
        chk_q   <= '0;
`endif
      end
      if (xfer) begin
        case (state_q)
          LEN0: len_q[8:0] <= i_s_data[8:0];
          LEN1: begin
            len_q <= hdr_len;
            if ((hdr_len != 12'd0) && hdr_oversize) o_err <= 1'b1;
          end
          DATA: begin
            o_imem_we   <= 1'b1;
            o_imem_addr <= o_count[g_IMEM_ADDR-1:0];
            o_imem_data <= i_s_data;
            o_count     <= o_count + 1'b1;
`ifdef PROG_LOADER_CHECKSUM_EN
            chk_q       <= chk_q ^ i_s_data;
`endif
          end
`ifdef PROG_LOADER_CHECKSUM_EN
          CHK:  if (!chk_match) o_err <= 1'b1;
`endif
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: directed self-checking bench for prog_loader (default parameters).
// Follows PROG_LOADER_CHECKSUM_EN to send trailing checksum words when enabled.
module tb_prog_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        s_valid;
  logic        s_ready;
  logic [8:0]  s_data;
  logic        imem_we;
  logic [10:0] imem_addr;
  logic [8:0]  imem_data;
  logic        cpu_rst;
  logic        busy;
  logic        err;
  logic [11:0] count;

  int n_checks = 0;
  int n_fail   = 0;
  int we_cnt   = 0;
  logic [10:0] we_addr_q[$];
  logic [8:0]  we_data_q[$];
`ifdef PROG_LOADER_CHECKSUM_EN
  logic [8:0]  exp_chk = 9'h000;
`endif

  prog_loader dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_start     (start),
    .i_s_valid   (s_valid),
    .o_s_ready   (s_ready),
    .i_s_data    (s_data),
    .o_imem_we   (imem_we),
    .o_imem_addr (imem_addr),
    .o_imem_data (imem_data),
    .o_cpu_rst   (cpu_rst),
    .o_busy      (busy),
    .o_err       (err),
    .o_count     (count)
  );

  // Free-running clock, rising edge active.
  always #5 clk = ~clk;

  // Record every write strobe shortly after the edge that produced it.
  always @(posedge clk) begin
    #2;
    if (imem_we === 1'b1) begin
      we_cnt++;
      we_addr_q.push_back(imem_addr);
      we_data_q.push_back(imem_data);
    end
  end

  task automatic reset_chk();
`ifdef PROG_LOADER_CHECKSUM_EN
    exp_chk = 9'h000;
`endif
  endtask

  // Offer one word from a falling edge; returns on the falling edge after it transferred.
  task automatic send_word(input logic [8:0] w);
    int n;
    n = 0;
    s_valid = 1'b1;
    s_data  = w;
    while (s_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (s_ready !== 1'b1) begin
      n_checks++; n_fail++;
      $display("[TB] FAIL send_timeout: ready=%b required 1", s_ready);
    end else begin
      @(negedge clk);
    end
    s_valid = 1'b0;
  endtask

  task automatic send_data(input logic [8:0] w);
`ifdef PROG_LOADER_CHECKSUM_EN
    exp_chk = exp_chk ^ w;
`endif
    send_word(w);
  endtask

  task automatic finish_load();
`ifdef PROG_LOADER_CHECKSUM_EN
    send_word(exp_chk);
`endif
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    reset_chk();
  endtask

  task automatic test_reset();
    logic [8:0] img [3];
    img = '{9'h005, 9'h00C, 9'h1FE};
    rst = 1'b1; start = 1'b0; s_valid = 1'b0; s_data = 9'h000;
    repeat (3) @(negedge clk);
    n_checks++; if (cpu_rst !== 1'b1) begin n_fail++; $display("[TB] FAIL rst_cpu_rst: got %b want 1", cpu_rst); end
    n_checks++; if (s_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_ready: got %b want 0", s_ready); end
    n_checks++; if (imem_we !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_we: got %b want 0", imem_we); end
    n_checks++; if (imem_addr !== 11'd0) begin n_fail++; $display("[TB] FAIL rst_addr: got %0d want 0", imem_addr); end
    n_checks++; if (imem_data !== 9'd0) begin n_fail++; $display("[TB] FAIL rst_data: got %h want 000", imem_data); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_busy: got %b want 0", busy); end
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_err: got %b want 0", err); end
    n_checks++; if (count !== 12'd0) begin n_fail++; $display("[TB] FAIL rst_count: got %0d want 0", count); end
    rst = 1'b0;
    reset_chk();
    @(negedge clk);
    n_checks++; if (s_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL autostart_ready: got %b want 1", s_ready); end
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("[TB] FAIL autostart_busy: got %b want 1", busy); end
    send_word(9'h003);
    send_word(9'h000);
    for (int k = 0; k < 3; k++) begin
      send_data(img[k]);
      n_checks++; if (imem_we !== 1'b1) begin n_fail++; $display("[TB] FAIL boot_we%0d: got %b want 1", k, imem_we); end
      n_checks++; if (imem_addr !== 11'(k)) begin n_fail++; $display("[TB] FAIL boot_addr%0d: got %0d want %0d", k, imem_addr, k); end
      n_checks++; if (imem_data !== img[k]) begin n_fail++; $display("[TB] FAIL boot_data%0d: got %h want %h", k, imem_data, img[k]); end
      n_checks++; if (count !== 12'(k + 1)) begin n_fail++; $display("[TB] FAIL boot_count%0d: got %0d want %0d", k, count, k + 1); end
    end
    finish_load();
    n_checks++; if (busy !== 1'b1 || cpu_rst !== 1'b1 || s_ready !== 1'b0) begin
      n_fail++; $display("[TB] FAIL boot_release: busy=%b cpu_rst=%b ready=%b want 1 1 0", busy, cpu_rst, s_ready);
    end
    @(negedge clk);
    n_checks++; if (cpu_rst !== 1'b0) begin n_fail++; $display("[TB] FAIL boot_run_cpu_rst: got %b want 0", cpu_rst); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL boot_run_busy: got %b want 0", busy); end
  endtask

  task automatic test_reload_from_run();
    pulse_start();
    n_checks++; if (cpu_rst !== 1'b1) begin n_fail++; $display("[TB] FAIL reload_cpu_rst: got %b want 1", cpu_rst); end
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("[TB] FAIL reload_err: got %b want 0", err); end
    n_checks++; if (count !== 12'd0) begin n_fail++; $display("[TB] FAIL reload_count: got %0d want 0", count); end
    send_word(9'h002);
    send_word(9'h000);
    send_data(9'h111);
    n_checks++; if (imem_addr !== 11'd0 || imem_data !== 9'h111 || imem_we !== 1'b1) begin
      n_fail++; $display("[TB] FAIL reload_w0: we=%b addr=%0d data=%h want 1 0 111", imem_we, imem_addr, imem_data);
    end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n_checks++; if (busy !== 1'b1 || s_ready !== 1'b1 || count !== 12'd1) begin
      n_fail++; $display("[TB] FAIL start_ignored: busy=%b ready=%b count=%0d want 1 1 1", busy, s_ready, count);
    end
    send_data(9'h0A5);
    n_checks++; if (imem_addr !== 11'd1 || imem_data !== 9'h0A5 || imem_we !== 1'b1) begin
      n_fail++; $display("[TB] FAIL reload_w1: we=%b addr=%0d data=%h want 1 1 0a5", imem_we, imem_addr, imem_data);
    end
    finish_load();
    @(negedge clk);
    n_checks++; if (cpu_rst !== 1'b0) begin n_fail++; $display("[TB] FAIL reload_run: cpu_rst=%b want 0", cpu_rst); end
  endtask

  task automatic test_backpressure();
    int cnt0;
    int bad;
    logic [8:0] w;
    pulse_start();
    send_word(9'h010);
    send_word(9'h000);
    we_addr_q.delete();
    we_data_q.delete();
    cnt0 = we_cnt;
    for (int i = 0; i < 16; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      w = 9'(i * 37 + 3);
      send_data(w);
    end
    finish_load();
    repeat (2) @(negedge clk);
    n_checks++; if (we_cnt - cnt0 !== 16) begin n_fail++; $display("[TB] FAIL bp_we_count: got %0d want 16", we_cnt - cnt0); end
    bad = 0;
    for (int i = 0; i < 16; i++) begin
      w = 9'(i * 37 + 3);
      if (i >= we_addr_q.size()) bad++;
      else if (we_addr_q[i] !== 11'(i) || we_data_q[i] !== w) bad++;
    end
    n_checks++; if (bad !== 0) begin n_fail++; $display("[TB] FAIL bp_sequence: %0d bad entries, want 0", bad); end
    n_checks++; if (cpu_rst !== 1'b0) begin n_fail++; $display("[TB] FAIL bp_run: cpu_rst=%b want 0", cpu_rst); end
  endtask

  task automatic test_zero_length();
    int cnt0;
    pulse_start();
    cnt0 = we_cnt;
    send_word(9'h000);
    send_word(9'h000);
    finish_load();
    n_checks++; if (busy !== 1'b1 || cpu_rst !== 1'b1 || s_ready !== 1'b0) begin
      n_fail++; $display("[TB] FAIL zero_release: busy=%b cpu_rst=%b ready=%b want 1 1 0", busy, cpu_rst, s_ready);
    end
    @(negedge clk);
    n_checks++; if (cpu_rst !== 1'b0) begin n_fail++; $display("[TB] FAIL zero_run: cpu_rst=%b want 0", cpu_rst); end
    @(negedge clk);
    n_checks++; if (we_cnt !== cnt0) begin n_fail++; $display("[TB] FAIL zero_no_we: got %0d strobes want 0", we_cnt - cnt0); end
  endtask

  task automatic test_oversize_and_full();
    int cnt0;
    int bad;
    pulse_start();
    send_word(9'h001);
    send_word(9'h004);
    n_checks++; if (err !== 1'b1) begin n_fail++; $display("[TB] FAIL over_err: got %b want 1", err); end
    n_checks++; if (s_ready !== 1'b0 || busy !== 1'b0 || cpu_rst !== 1'b1) begin
      n_fail++; $display("[TB] FAIL over_idle: ready=%b busy=%b cpu_rst=%b want 0 0 1", s_ready, busy, cpu_rst);
    end
    repeat (3) @(negedge clk);
    n_checks++; if (s_ready !== 1'b0 || cpu_rst !== 1'b1 || err !== 1'b1) begin
      n_fail++; $display("[TB] FAIL over_stays_idle: ready=%b cpu_rst=%b err=%b want 0 1 1", s_ready, cpu_rst, err);
    end
    pulse_start();
    n_checks++; if (err !== 1'b0 || count !== 12'd0 || s_ready !== 1'b1) begin
      n_fail++; $display("[TB] FAIL idle_start: err=%b count=%0d ready=%b want 0 0 1", err, count, s_ready);
    end
    send_word(9'h000);
    send_word(9'h004);
    we_addr_q.delete();
    we_data_q.delete();
    cnt0 = we_cnt;
    for (int i = 0; i < 2048; i++) send_data(9'(i));
    n_checks++; if (count !== 12'd2048 || imem_addr !== 11'd2047) begin
      n_fail++; $display("[TB] FAIL full_last: count=%0d addr=%0d want 2048 2047", count, imem_addr);
    end
    finish_load();
    repeat (2) @(negedge clk);
    n_checks++; if (we_cnt - cnt0 !== 2048) begin n_fail++; $display("[TB] FAIL full_we_count: got %0d want 2048", we_cnt - cnt0); end
    bad = 0;
    for (int i = 0; i < 2048; i++) begin
      if (i >= we_addr_q.size()) bad++;
      else if (we_addr_q[i] !== 11'(i) || we_data_q[i] !== 9'(i)) bad++;
    end
    n_checks++; if (bad !== 0) begin n_fail++; $display("[TB] FAIL full_sequence: %0d bad entries, want 0", bad); end
    n_checks++; if (cpu_rst !== 1'b0 || err !== 1'b0) begin
      n_fail++; $display("[TB] FAIL full_run: cpu_rst=%b err=%b want 0 0", cpu_rst, err);
    end
  endtask

  task automatic test_ignored_inputs();
    int cnt0;
    cnt0 = we_cnt;
    s_valid = 1'b1;
    s_data  = 9'h1FF;
    repeat (3) @(negedge clk);
    n_checks++; if (we_cnt !== cnt0 || cpu_rst !== 1'b0 || s_ready !== 1'b0) begin
      n_fail++; $display("[TB] FAIL valid_in_run: strobes=%0d cpu_rst=%b ready=%b want 0 0 0", we_cnt - cnt0, cpu_rst, s_ready);
    end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    s_valid = 1'b0;
    reset_chk();
    n_checks++; if (s_ready !== 1'b1 || cpu_rst !== 1'b1 || count !== 12'd0) begin
      n_fail++; $display("[TB] FAIL start_wins: ready=%b cpu_rst=%b count=%0d want 1 1 0", s_ready, cpu_rst, count);
    end
    send_word(9'h001);
    send_word(9'h000);
    send_data(9'h1AB);
    n_checks++; if (imem_we !== 1'b1 || imem_addr !== 11'd0 || imem_data !== 9'h1AB) begin
      n_fail++; $display("[TB] FAIL start_wins_w0: we=%b addr=%0d data=%h want 1 0 1ab", imem_we, imem_addr, imem_data);
    end
    finish_load();
    @(negedge clk);
    n_checks++; if (cpu_rst !== 1'b0) begin n_fail++; $display("[TB] FAIL start_wins_run: cpu_rst=%b want 0", cpu_rst); end
  endtask

  task automatic test_reset_mid_data();
    pulse_start();
    send_word(9'h004);
    send_word(9'h000);
    send_data(9'h033);
    send_data(9'h044);
    rst = 1'b1;
    #1;
    n_checks++; if (cpu_rst !== 1'b1 || s_ready !== 1'b0 || imem_we !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("[TB] FAIL abort_ctrl: cpu_rst=%b ready=%b we=%b busy=%b want 1 0 0 0", cpu_rst, s_ready, imem_we, busy);
    end
    n_checks++; if (imem_addr !== 11'd0 || imem_data !== 9'd0 || err !== 1'b0 || count !== 12'd0) begin
      n_fail++; $display("[TB] FAIL abort_data: addr=%0d data=%h err=%b count=%0d want 0 000 0 0", imem_addr, imem_data, err, count);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    reset_chk();
    @(negedge clk);
    n_checks++; if (s_ready !== 1'b1 || cpu_rst !== 1'b1) begin
      n_fail++; $display("[TB] FAIL abort_autostart: ready=%b cpu_rst=%b want 1 1", s_ready, cpu_rst);
    end
  endtask

`ifdef PROG_LOADER_CHECKSUM_EN
  task automatic test_checksum();
    send_word(9'h002);
    send_word(9'h000);
    send_data(9'h0F0);
    send_data(9'h00F);
    send_word(9'h0FF);
    @(negedge clk);
    n_checks++; if (cpu_rst !== 1'b0 || err !== 1'b0) begin
      n_fail++; $display("[TB] FAIL chk_good: cpu_rst=%b err=%b want 0 0", cpu_rst, err);
    end
    pulse_start();
    send_word(9'h002);
    send_word(9'h000);
    send_data(9'h0F0);
    send_data(9'h00F);
    send_word(9'h0FE);
    n_checks++; if (err !== 1'b1 || s_ready !== 1'b0 || busy !== 1'b0 || cpu_rst !== 1'b1) begin
      n_fail++; $display("[TB] FAIL chk_bad: err=%b ready=%b busy=%b cpu_rst=%b want 1 0 0 1", err, s_ready, busy, cpu_rst);
    end
  endtask
`endif

  // Run the scenarios in order; each one leaves the loader in a known state for the next.
  initial begin
    test_reset();
    test_reload_from_run();
    test_backpressure();
    test_zero_length();
    test_oversize_and_full();
    test_ignored_inputs();
    test_reset_mid_data();
`ifdef PROG_LOADER_CHECKSUM_EN
    test_checksum();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
